lsu_mem_ctrl: RTL and testbench

//  Sequences every load/store of the core onto a req/gnt/rvalid data-memory port.
//  - Stalls the single-cycle core until the access completes.
//  - Produces byte enables and lane-replicated write data.
//  - Sign/zero-extends load data.
//  - Reports misaligned or timed-out accesses as errors.
//  - Sits between decode/ALU (effective address) and the data memory.

---
 rtl/lsu_mem_ctrl_pkg.sv | 48 ++++
 rtl/lsu_mem_ctrl_align.sv | 48 ++++
 rtl/lsu_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store unit and its data-align sub-block.
// Build option: LSU_MISALIGN_TRAP_EN (consumed by lsu_mem_ctrl).
package lsu_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        LSU_LW,
        LSU_LH,
        LSU_LB,
        LSU_LHU,
        LSU_LBU,
        LSU_SW,
        LSU_SH,
        LSU_SB
    } load_store_func_code;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

    parameter int LSU_TIMEOUT_DEFAULT = 16;

    function automatic logic is_store(input load_store_func_code f);
        return (f == LSU_SW) || (f == LSU_SH) || (f == LSU_SB);
    endfunction

    function automatic logic is_misaligned(input load_store_func_code f, input logic [1:0] a);
        logic half;
        logic word;
        half = (f == LSU_LH) || (f == LSU_LHU) || (f == LSU_SH);
        word = (f == LSU_LW) || (f == LSU_SW);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

    // Natural alignment: halfwords keep only a[1], words always use lane 0.
    function automatic logic [1:0] align_offset(input load_store_func_code f, input logic [1:0] a);
        logic [1:0] off;
        case (f)
            LSU_LH, LSU_LHU, LSU_SH: off = a & 2'b10;
            LSU_LW, LSU_SW:          off = 2'b00;
            default:                 off = a;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational byte-lane logic: byte enables, replicated store data, extended load data.
module lsu_data_align
    import lsu_mem_ctrl_pkg::*;
(
    input  load_store_func_code func_i,
    input  logic [1:0]          offset_i,
    input  logic [31:0]         wdata_i,
    input  logic [31:0]         rdata_i,
    output logic [3:0]          be_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (func_i)
            LSU_SB: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            LSU_SH: begin
                be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            LSU_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: rdata_o = {24'h0, byte_sel};
            LSU_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: rdata_o = {16'h0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer onto a req/gnt/rvalid data port, stalling the core until completion.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into error completions.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req_i,
    input  logic [2:0]  lsu_func_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_stall_o,
    output logic        lsu_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    // Wide enough to pass TIMEOUT_CYCLES when a grant lands on the last REQ cycle.
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e          state_q, state_d;
    load_store_func_code func_q, func_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    load_store_func_code func_in;
    logic                trap;
    logic [3:0]          be;
    logic [31:0]         wdata_rep;
    logic [31:0]         rdata_ext;

    assign func_in = load_store_func_code'(lsu_func_i);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(func_in, lsu_addr_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_data_align u_align (
        .func_i   (func_q),
        .offset_i (align_offset(func_q, addr_q[1:0])),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata_i),
        .be_o     (be),
        .wdata_o  (wdata_rep),
        .rdata_o  (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i) begin
                    func_d  = func_in;
                    addr_d  = lsu_addr_i;
                    wdata_d = lsu_wdata_i;
                    if (trap) begin
                        state_d = LSU_DONE;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = LSU_REQ;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_gnt_i) begin
                    req_d = 1'b0;
                    if (is_store(func_q)) begin
                        state_d = LSU_DONE;
                        valid_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    req_d   = 1'b0;
                    state_d = LSU_DONE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rvalid_i) begin
                    state_d = LSU_DONE;
                    valid_d = 1'b1;
                    rdata_d = rdata_ext;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = LSU_DONE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            func_q  <= LSU_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the stall so the core is released in the same instant the access is dropped.
    assign lsu_stall_o = lsu_req_i & ~rst & (state_q != LSU_DONE);
    assign lsu_valid_o = valid_q;
    assign lsu_err_o   = err_q;
    assign lsu_rdata_o = rdata_q;

    assign mem_req_o   = req_q;
    assign mem_we_o    = req_q & is_store(func_q);
    assign mem_be_o    = req_q ? be : 4'b0000;
    assign mem_addr_o  = req_q ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata_o = req_q ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a cycle-stepped memory responder and expected-data queue.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_i;
  logic [2:0]  lsu_func_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_stall_o;
  logic        lsu_valid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_req_i    (lsu_req_i),
    .lsu_func_i   (lsu_func_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_stall_o  (lsu_stall_o),
    .lsu_valid_o  (lsu_valid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // observations of the last access
  logic [31:0] o_stall;
  int          o_req_cycles;
  int          o_valid_cyc;
  logic [3:0]  o_be;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic        o_we;
  logic [31:0] o_rdata;
  logic        o_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Starts at posedge+1 with the FSM in IDLE; memory grants after gnt_dly requesting
  // cycles (-1 = never) and returns data rv_dly cycles after the grant.
  task automatic do_access(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] mw,
                           input int gnt_dly, input int rv_dly);
    int cyc;
    int req_n;
    int gnt_cyc;
    bit done;
    bit is_ld;
    cyc = 1; req_n = 0; gnt_cyc = -1; done = 0;
    is_ld = !(f inside {LSU_SW, LSU_SH, LSU_SB});
    o_stall = 0; o_req_cycles = 0; o_valid_cyc = 0;
    o_be = 0; o_addr = 0; o_wdata = 0; o_we = 0; o_rdata = 0; o_err = 0;
    lsu_req_i = 1'b1; lsu_func_i = f; lsu_addr_i = a; lsu_wdata_i = wd;
    while (!done && cyc <= 20) begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      if (mem_req_o) begin
        o_req_cycles++;
        if (gnt_dly >= 0 && req_n == gnt_dly) begin
          mem_gnt_i = 1'b1; gnt_cyc = cyc;
          o_be = mem_be_o; o_addr = mem_addr_o; o_wdata = mem_wdata_o; o_we = mem_we_o;
        end
        req_n++;
      end
      if (is_ld && gnt_cyc >= 0 && cyc == gnt_cyc + rv_dly) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = mw;
      end
      @(negedge clk);
      if (lsu_stall_o) o_stall[cyc-1] = 1'b1;
      if (lsu_valid_o) begin
        done = 1; o_valid_cyc = cyc; o_rdata = lsu_rdata_o; o_err = lsu_err_o;
      end
      @(posedge clk); #1;
      cyc++;
    end
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    check({tag, "_completed"}, 32'(done), 32'd1);
    if (exp_q.size() != 0) check({tag, "_rdata"}, o_rdata, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; lsu_req_i = 1'b0; lsu_func_i = 3'd0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(lsu_valid_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_be", 32'(mem_be_o), 32'd0);
    check("rst_rdata", lsu_rdata_o, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(LSU_IDLE));
    @(posedge clk); #1;

    // 1: SW, 3-cycle store
    exp_q.push_back(32'h0);
    do_access("sw", LSU_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
    check("sw_be", 32'(o_be), 32'hF);
    check("sw_addr", o_addr, 32'h100);
    check("sw_wdata", o_wdata, 32'hDEADBEEF);
    check("sw_we", 32'(o_we), 32'd1);
    check("sw_valid_cyc", 32'(o_valid_cyc), 32'd3);
    check("sw_stall", o_stall, 32'h3);
    check("sw_err", 32'(o_err), 32'd0);

    // 2: SB to the top byte lane
    exp_q.push_back(32'h0);
    do_access("sb", LSU_SB, 32'h103, 32'h000000A5, 32'h0, 0, 1);
    check("sb_be", 32'(o_be), 32'h8);
    check("sb_wdata", o_wdata, 32'hA5A5A5A5);
    check("sb_addr", o_addr, 32'h100);

    // SH to upper half
    exp_q.push_back(32'h0);
    do_access("sh", LSU_SH, 32'h102, 32'h0000BEEF, 32'h0, 0, 1);
    check("sh_be", 32'(o_be), 32'hC);
    check("sh_wdata", o_wdata, 32'hBEEFBEEF);

    // 3: LB / LBU lane 2 with rvalid 3 cycles after grant (lands on the last counted cycle)
    exp_q.push_back(32'hFFFFFFF4);
    do_access("lb", LSU_LB, 32'h202, 32'h0, 32'h12F45678, 0, 3);
    check("lb_be", 32'(o_be), 32'hF);
    check("lb_we", 32'(o_we), 32'd0);
    check("lb_addr", o_addr, 32'h200);
    check("lb_valid_cyc", 32'(o_valid_cyc), 32'd6);
    check("lb_err", 32'(o_err), 32'd0);
    exp_q.push_back(32'h000000F4);
    do_access("lbu", LSU_LBU, 32'h202, 32'h0, 32'h12F45678, 0, 3);

    // 4-cycle load, LH / LHU upper half
    exp_q.push_back(32'hFFFF8001);
    do_access("lh", LSU_LH, 32'h202, 32'h0, 32'h80011234, 0, 1);
    check("lh_valid_cyc", 32'(o_valid_cyc), 32'd4);
    check("lh_stall", o_stall, 32'h7);
    exp_q.push_back(32'h00008001);
    do_access("lhu", LSU_LHU, 32'h202, 32'h0, 32'h80011234, 1, 1);
    check("lhu_valid_cyc", 32'(o_valid_cyc), 32'd5);

    // 4: misaligned LH
`ifdef LSU_MISALIGN_TRAP_EN
    exp_q.push_back(32'h0);
    do_access("lh_mis", LSU_LH, 32'h201, 32'h0, 32'h1234ABCD, 0, 1);
    check("lh_mis_err", 32'(o_err), 32'd1);
    check("lh_mis_req_cycles", 32'(o_req_cycles), 32'd0);
    check("lh_mis_valid_cyc", 32'(o_valid_cyc), 32'd2);
`else
    exp_q.push_back(32'hFFFFABCD);
    do_access("lh_mis", LSU_LH, 32'h201, 32'h0, 32'h1234ABCD, 0, 1);
    check("lh_mis_addr", o_addr, 32'h200);
    check("lh_mis_err", 32'(o_err), 32'd0);
`endif

    // 5: LW timeout with no grant, then a late rvalid
    exp_q.push_back(32'h0);
    do_access("lw_to", LSU_LW, 32'h300, 32'h0, 32'h0, -1, 1);
    check("lw_to_req_cycles", 32'(o_req_cycles), 32'd4);
    check("lw_to_err", 32'(o_err), 32'd1);
    check("lw_to_valid_cyc", 32'(o_valid_cyc), 32'd6);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
    @(negedge clk);
    check("late_rv_valid", 32'(lsu_valid_o), 32'd0);
    @(posedge clk); #1 mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("late_rv_valid2", 32'(lsu_valid_o), 32'd0);
    check("late_rv_state", 32'(dut.state_q), 32'(LSU_IDLE));
    check("late_rv_rdata", lsu_rdata_o, 32'h0);
    @(posedge clk); #1;

    // 6: reset while in WAIT
    lsu_req_i = 1'b1; lsu_func_i = LSU_LW; lsu_addr_i = 32'h400;
    @(posedge clk); #1;
    check("rw_req", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(posedge clk); #1 mem_gnt_i = 1'b0;
    check("rw_wait", 32'(dut.state_q), 32'(LSU_WAIT));
    #2 rst = 1'b1;
    #1;
    check("rw_mem_req", 32'(mem_req_o), 32'd0);
    check("rw_stall", 32'(lsu_stall_o), 32'd0);
    check("rw_valid", 32'(lsu_valid_o), 32'd0);
    check("rw_state", 32'(dut.state_q), 32'(LSU_IDLE));
    @(negedge clk) lsu_req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // reset while in REQ drops mem_req_o without a clock edge
    lsu_req_i = 1'b1; lsu_func_i = LSU_SW; lsu_addr_i = 32'h500;
    @(posedge clk); #1;
    check("rr_req", 32'(mem_req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rr_mem_req", 32'(mem_req_o), 32'd0);
    @(negedge clk) lsu_req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    exp_q.push_back(32'hCAFEF00D);
    do_access("lw_after_rst", LSU_LW, 32'h404, 32'h0, 32'hCAFEF00D, 0, 1);
    check("lw_after_rst_valid_cyc", 32'(o_valid_cyc), 32'd4);
    check("lw_after_rst_err", 32'(o_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
